// File: rtl/d_ff_en_rr_pkg.sv
// Shared types and width helpers for the round-robin register arbiter.
package d_ff_en_rr_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_e;

  // Index width, kept at least 1 bit so N=2 still gets a usable index.
  function automatic int idx_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  // Counter must be able to hold the value MAX_BURST itself.
  function automatic int cnt_w(input int max_burst);
    return (max_burst > 1) ? $clog2(max_burst + 1) : 1;
  endfunction

endpackage

// File: rtl/d_ff_en_rr_arb_rr_pick.sv
// Round-robin picker: first asserted request at or after ptr, wrapping modulo N.
module rr_pick
  import d_ff_en_rr_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [idx_w(N)-1:0]  ptr,
  output logic                 gnt_valid,
  output logic [idx_w(N)-1:0]  gnt_idx
);

  localparam int IDX_W = idx_w(N);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [IDX_W:0] off;
  logic [IDX_W:0] sum;

  always_comb begin
    // Rotate so that the requester at ptr sits in bit 0.
    dbl = {req, req} >> ptr;
    rot = dbl[N-1:0];
    off = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) off = (IDX_W + 1)'(i);
    end
    // Un-rotate; explicit wrap keeps non-power-of-two N correct.
    sum = {1'b0, ptr} + off;
    if (sum >= (IDX_W + 1)'(N)) sum = sum - (IDX_W + 1)'(N);
    gnt_idx   = sum[IDX_W-1:0];
    gnt_valid = |req;
  end

endmodule

// File: rtl/d_ff_en_rr_arb.sv
// Shares one enable-gated W-bit register between N requesters with round-robin
// arbitration and capped locked bursts; ack is a registered one-cycle pulse.
module d_ff_en_rr_arb
  import d_ff_en_rr_pkg::*;
#(
  parameter int N         = 4,
  parameter int W         = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N-1:0]        req,
  input  logic [N-1:0]        lock,
  input  logic [N*W-1:0]      data,
  output logic [N-1:0]        ack,
  output logic [W-1:0]        q,
  output logic [idx_w(N)-1:0] q_owner,
  output logic                q_valid,
  output logic                busy
);

  localparam int IDX_W = idx_w(N);
  localparam int CNT_W = cnt_w(MAX_BURST);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_BURST);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [N-1:0]       ack_q, ack_d;
  logic [W-1:0]       q_q, q_d;
  logic [IDX_W-1:0]   q_owner_q, q_owner_d;
  logic               q_valid_q, q_valid_d;

  logic               pick_valid;
  logic [IDX_W-1:0]   pick_idx;
  logic               hold;
  logic               gnt_valid;
  logic [IDX_W-1:0]   gnt_idx;
  logic [W-1:0]       slice [N];

  rr_pick #(.N(N)) u_pick (
    .req       (req),
    .ptr       (ptr_q),
    .gnt_valid (pick_valid),
    .gnt_idx   (pick_idx)
  );

  // Next-state: burst continuation first, otherwise a fresh round-robin pick
  // in the same cycle so an ending burst never leaves an idle bubble.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    hold      = (state_q == LOCK) && req[owner_q] && lock[owner_q] && (cnt_q < CNT_MAX);
    if (hold) begin
      gnt_valid = 1'b1;
      gnt_idx   = owner_q;
      cnt_d     = cnt_q + CNT_W'(1);
    end else if (pick_valid) begin
      gnt_valid = 1'b1;
      gnt_idx   = pick_idx;
      ptr_d     = (pick_idx == LAST_IDX) ? '0 : pick_idx + IDX_W'(1);
      if (lock[pick_idx]) begin
        state_d = LOCK;
        owner_d = pick_idx;
        cnt_d   = CNT_W'(1);
      end else begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    end else begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) slice[i] = data[i*W +: W];
    ack_d     = '0;
    q_d       = q_q;
    q_owner_d = q_owner_q;
    q_valid_d = q_valid_q;
    if (gnt_valid) begin
      ack_d[gnt_idx] = 1'b1;
      q_d            = slice[gnt_idx];
      q_owner_d      = gnt_idx;
      q_valid_d      = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      owner_q   <= '0;
      cnt_q     <= '0;
      ack_q     <= '0;
      q_q       <= '0;
      q_owner_q <= '0;
      q_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      cnt_q     <= cnt_d;
      ack_q     <= ack_d;
      q_q       <= q_d;
      q_owner_q <= q_owner_d;
      q_valid_q <= q_valid_d;
    end
  end

  always_comb begin
    busy    = (state_q == LOCK);
    ack     = ack_q;
    q       = q_q;
    q_owner = q_owner_q;
    q_valid = q_valid_q;
  end

endmodule

// File: tb/tb_d_ff_en_rr_arb.sv
// Randomized and directed bench for d_ff_en_rr_arb against a behavioural model.
module tb_d_ff_en_rr_arb;

  localparam int N         = 4;
  localparam int W         = 8;
  localparam int MAX_BURST = 4;

  // Handshake: req/lock/data are driven between edges; a grant decided from
  // them is written at the next rising edge and ack pulses for the cycle after.
  logic             clk;
  logic             rst;
  logic [N-1:0]     req;
  logic [N-1:0]     lock;
  logic [N*W-1:0]   data;
  logic [N-1:0]     ack;
  logic [W-1:0]     q;
  logic [1:0]       q_owner;
  logic             q_valid;
  logic             busy;

  int n_checks;
  int n_fail;

  // Behavioural model state.
  int           m_ptr;
  int           m_owner;
  int           m_run;
  bit           m_locked;
  logic [W-1:0] m_q;
  int           m_q_owner;
  bit           m_valid;
  logic [N-1:0] m_ack;
  logic [W-1:0] exp_q[$];

  int t3_ack [6] = '{1, 1, 1, 1, 4, 1};
  int t3_busy[6] = '{1, 1, 1, 1, 0, 1};
  int t6_ack [3] = '{2, 4, 2};

  d_ff_en_rr_arb #(.N(N), .W(W), .MAX_BURST(MAX_BURST)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .lock    (lock),
    .data    (data),
    .ack     (ack),
    .q       (q),
    .q_owner (q_owner),
    .q_valid (q_valid),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_ptr = 0; m_owner = 0; m_run = 0; m_locked = 0;
    m_q = '0; m_q_owner = 0; m_valid = 0; m_ack = '0;
    exp_q.delete();
  endfunction

  function automatic int first_from(input logic [N-1:0] r, input int start);
    for (int k = 0; k < N; k++) begin
      if (r[(start + k) % N]) return (start + k) % N;
    end
    return -1;
  endfunction

  // Decide who writes at the coming edge from the rules, using current inputs.
  function automatic void model_step();
    int g;
    if (m_locked && req[m_owner] && lock[m_owner] && m_run < MAX_BURST) begin
      g = m_owner;
      m_run++;
    end else begin
      g = first_from(req, m_ptr);
      m_locked = 0;
      if (g >= 0) begin
        m_ptr = (g + 1) % N;
        if (lock[g]) begin
          m_locked = 1; m_owner = g; m_run = 1;
        end
      end
    end
    m_ack = '0;
    if (g >= 0) begin
      m_ack[g]  = 1'b1;
      m_q       = data[g*W +: W];
      m_q_owner = g;
      m_valid   = 1;
      exp_q.push_back(data[g*W +: W]);
    end
  endfunction

  task automatic compare_all();
    logic [W-1:0] e;
    check("ack", 32'(ack), 32'(m_ack));
    check("q", 32'(q), 32'(m_q));
    check("q_owner", 32'(q_owner), 32'(m_q_owner));
    check("q_valid", 32'(q_valid), 32'(m_valid));
    check("busy", 32'(busy), 32'(m_locked));
    if (m_ack != '0) begin
      if (exp_q.size() == 0) begin
        check("exp_q_empty", 32'(1), 32'(0));
      end else begin
        e = exp_q.pop_front();
        check("q_written", 32'(q), 32'(e));
      end
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; req = '0; lock = '0;
    #1;
    model_reset();
    check("rst_q", 32'(q), 32'(0));
    check("rst_ack", 32'(ack), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_valid", 32'(q_valid), 32'(0));
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic drive(input logic [N-1:0] r, input logic [N-1:0] l);
    req  = r;
    lock = l;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst  = 1'b0;
    req  = '0;
    lock = '0;
    for (int i = 0; i < N; i++) data[i*W +: W] = W'(8'h10 + i);
    model_reset();

    // Idle after reset.
    do_reset();
    drive(4'b0000, 4'b0000);
    for (int k = 0; k < 5; k++) begin
      step();
      check("t1_valid", 32'(q_valid), 32'(0));
      check("t1_ack", 32'(ack), 32'(0));
    end

    // Plain round robin over all four.
    do_reset();
    drive(4'b1111, 4'b0000);
    for (int k = 0; k < 8; k++) begin
      step();
      check("t2_ack", 32'(ack), 32'(1 << (k % 4)));
      check("t2_q", 32'(q), 32'(8'h10 + k % 4));
    end

    // Capped burst for requester 0, then requester 2 with no bubble.
    do_reset();
    drive(4'b0101, 4'b0001);
    for (int k = 0; k < 6; k++) begin
      step();
      check("t3_ack", 32'(ack), 32'(t3_ack[k]));
      check("t3_busy", 32'(busy), 32'(t3_busy[k]));
    end

    // Lone locked requester: re-granted across burst boundaries.
    do_reset();
    drive(4'b0001, 4'b0001);
    for (int k = 0; k < 10; k++) begin
      step();
      check("t4_ack", 32'(ack), 32'(1));
      check("t4_owner", 32'(q_owner), 32'(0));
    end

    // Asynchronous reset in the middle of a burst.
    do_reset();
    drive(4'b0001, 4'b0001);
    step();
    step();
    @(negedge clk);
    rst = 1'b0;
    #1;
    model_reset();
    check("t5_q", 32'(q), 32'(0));
    check("t5_ack", 32'(ack), 32'(0));
    check("t5_busy", 32'(busy), 32'(0));
    check("t5_valid", 32'(q_valid), 32'(0));
    @(negedge clk);
    rst = 1'b1;
    drive(4'b1000, 4'b0000);
    step();
    check("t5_ack3", 32'(ack), 32'(8));
    check("t5_owner3", 32'(q_owner), 32'(3));

    // Requester 1 drops lock mid-burst.
    do_reset();
    drive(4'b0110, 4'b0010);
    step();
    check("t6_ack0", 32'(ack), 32'(t6_ack[0]));
    drive(4'b0110, 4'b0000);
    for (int k = 1; k < 3; k++) begin
      step();
      check("t6_ack", 32'(ack), 32'(t6_ack[k]));
    end

    // Random traffic with occasional reset.
    do_reset();
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 2) != 0) req = N'($urandom_range(0, 15));
      if ($urandom_range(0, 2) != 0) lock = N'($urandom_range(0, 15));
      for (int i = 0; i < N; i++) data[i*W +: W] = W'($urandom_range(0, 255));
      if ($urandom_range(0, 99) == 0) do_reset();
      else step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/d_ff_en_rr_arb.md
Name: d_ff_en_rr_arb

Overview:
- Round-robin arbiter and load sequencer that shares one enable-gated W-bit register between N requesters.
- Each cycle it picks at most one requester, asserts the register's load enable with that requester's data, and returns a one-cycle ack.
- Supports locked bursts, where a requester keeps the register for consecutive writes, capped at MAX_BURST cycles.
- Sits between producer blocks and a shared configuration/status register.

Parameters:
- N, 4, number of requesters (2..16).
- W, 8, data/register width.
- MAX_BURST, 4, maximum consecutive grants to one locked requester (>=1).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset; clears all state immediately when 0.
- req  in  N  per-requester write request, level.
- lock  in  N  per-requester burst hold; meaningful only together with req.
- data  in  N*W  requester data; slice i is bits [i*W +: W].
- ack  out  N  one-hot (or zero) pulse, registered: write of requester i completed at the preceding edge.
- q  out  W  shared register contents.
- q_owner  out  clog2(N)  index of the requester that last wrote q.
- q_valid  out  1  1 once q has been written since reset.
- busy  out  1  1 while in LOCK state.

Behaviour:
- Reset (rst=0, asynchronous):
  - q=0, q_owner=0, q_valid=0, ack=0, busy=0.
  - State IDLE, round-robin pointer ptr=0, burst counter cnt=0.
- Grant is combinational from the registered state and the current req/lock. Only the edge updates are registered.
- Latency: req sampled in cycle t; at edge end-of-t, q<=data[g], q_owner<=g, q_valid<=1. ack[g]=1 during cycle t+1 only.
- No request: no grant. q holds, ack=0.
- FSM IDLE:
  - Grant g = first asserted req searching ptr, ptr+1, ... mod N.
  - On grant: ptr<=g+1 mod N.
  - If lock[g]=1: go to LOCK, owner<=g, cnt<=1. Else stay IDLE.
- FSM LOCK (busy=1):
  - If req[owner] && lock[owner] && cnt<MAX_BURST: grant owner, cnt<=cnt+1, ptr unchanged.
  - Otherwise the burst ends in this same cycle with no idle bubble: arbitrate round-robin from ptr (= owner+1), so the owner ranks last.
    - If the new grant has lock=1: re-enter LOCK with cnt=1.
    - Else: go to IDLE.
  - If no requests: go to IDLE, no write.
- MAX_BURST=1: lock has no effect on fairness. Every cycle is a fresh round-robin decision.
- Requester keeping req=1 after its ack is a new request; it competes normally.
- Only one bit of ack is set per cycle. ack[i] never asserts without req[i] having been 1 in the previous cycle.
- Wrap-around: ptr increments modulo N. When N is not a power of two, the pointer wraps from N-1 to 0 explicitly.
- Inputs change only synchronously to clk. data is captured only for the granted requester; other slices are ignored.
- Reset asserted mid-burst aborts the burst: state, counter and outputs clear at once, and the first grant after release starts from requester 0.

Decomposition:
- Package d_ff_en_rr_pkg holds:
  - State encoding constants IDLE=1'b0, LOCK=1'b1.
  - Localparam helper for IDX_W = clog2(N), and the CNT_W width for MAX_BURST.
- One combinational sub-module rr_pick (N param): inputs req[N] and ptr; outputs gnt_valid and gnt_idx. It performs a rotate, a priority-encode and an un-rotate.
- Top level holds the FSM, counter, pointer, shared enable register and ack register.

Test Plan:
- Reset, then req=4'b0000 for 5 cycles -> q=0, q_valid=0, ack=0 throughout.
- All req=4'b1111, lock=0, data[i]=8'h10+i for 8 cycles -> ack order 0,1,2,3,0,1,2,3; q follows 8'h10,8'h11,8'h12,8'h13,...; each ack one cycle after its write edge.
- req=4'b0101, lock=4'b0001, MAX_BURST=4 -> requester 0 acked 4 consecutive cycles, busy=1, then requester 2 acked next cycle with no bubble; then requester 0 starts a new burst.
- req=4'b0001, lock=4'b0001 held 10 cycles -> ack[0] every cycle; cnt wraps via re-grant (bursts of 4); q_owner=0.
- Mid-burst (cnt=2), drive rst=0 between edges -> q, ack, busy, q_valid drop to 0 immediately. After release with req=4'b1000, the first ack is ack[3], next write edge.
- Requester 1 drops lock while still requesting during LOCK with req=4'b0110 -> burst ends that cycle; requester 2 is granted next, then requester 1.
